// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_alusrc,
  input  logic                     id_memtoreg,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     id_memwrite,
  input  logic                     id_branch,
  input  logic [1:0]               id_aluop,
  input  logic [3:0]               id_funct,
  input  logic [DATA_W-1:0]        id_pc,
  input  logic signed [DATA_W-1:0] id_rs1_data,
  input  logic signed [DATA_W-1:0] id_rs2_data,
  input  logic signed [DATA_W-1:0] id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     flush,
  input  logic                     ex_stall,
  output logic                     ex_valid,
  output logic                     ex_alusrc,
  output logic                     ex_memtoreg,
  output logic                     ex_regwrite,
  output logic                     ex_memread,
  output logic                     ex_memwrite,
  output logic                     ex_branch,
  output logic [1:0]               ex_aluop,
  output logic [3:0]               ex_funct,
  output logic [DATA_W-1:0]        ex_pc,
  output logic signed [DATA_W-1:0] ex_rs1_data,
  output logic signed [DATA_W-1:0] ex_rs2_data,
  output logic signed [DATA_W-1:0] ex_imm,
  output logic [REG_ADDR_W-1:0]    ex_rs1,
  output logic [REG_ADDR_W-1:0]    ex_rs2,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     id_hold,
  output logic [CNT_W-1:0]         bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic       uses_rs2;
  logic       load_use;
  logic [7:0] ctrl_p0;
  logic [7:0] ctrl_p1;
  logic       vld_p1;

  // ID side: hazard detection and control qualification
  assign uses_rs2 = !id_alusrc | id_memwrite;
  assign load_use = vld_p1 & ex_memread & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));
  assign id_hold  = !flush & (ex_stall | load_use);

  // An invalid ID slot never forwards its (possibly undefined) decoder outputs.
  assign ctrl_p0 = id_valid ? {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                               id_memwrite, id_branch, id_aluop} : 8'd0;

  // ID -> EX control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= 8'd0;
      bubble_cnt <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= 8'd0;
    end else if (ex_stall) begin
      vld_p1  <= vld_p1;
      ctrl_p1 <= ctrl_p1;
    end else if (load_use) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= 8'd0;
      bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      vld_p1  <= id_valid;
      ctrl_p1 <= ctrl_p0;
    end
  end

  // ID -> EX data and index registers; bubbles and flushes leave them as-is
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_funct    <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
    end else if (!flush && !ex_stall && !load_use) begin
      ex_funct    <= id_funct;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

  assign ex_valid = vld_p1;
  assign {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
          ex_memwrite, ex_branch, ex_aluop} = ctrl_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table plus randomized traffic against
// an instruction-level model of the ID/EX slot (default and 2-bit counter builds).
module tb_id_ex_stage;

  typedef struct packed {
    logic        rst, flush, stall, valid;
    logic        alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
  } in_t;

  typedef struct {
    in_t        in;
    bit         chk_hold;
    bit         exp_hold;
    bit         exp_valid;
    logic [4:0] exp_rd;
    int         exp_cnt;
    int         exp_cnt2;
  } vec_t;

  typedef struct {
    bit           init;
    bit           valid;
    bit           memread;
    logic [4:0]   rd;
    logic [8:0]   ctrl;
    logic [274:0] data;
    bit           known;
    int           cnt, cnt2;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0] id_aluop;
  logic [3:0] id_funct;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic flush, ex_stall;

  logic ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, id_hold;
  logic [1:0] ex_aluop;
  logic [3:0] ex_funct;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [15:0] bubble_cnt;

  logic d2_valid, d2_alusrc, d2_memtoreg, d2_regwrite, d2_memread, d2_memwrite, d2_branch, d2_id_hold;
  logic [1:0] d2_aluop;
  logic [3:0] d2_funct;
  logic [63:0] d2_pc, d2_rs1_data, d2_rs2_data, d2_imm;
  logic [4:0] d2_rs1, d2_rs2, d2_rd;
  logic [1:0] d2_bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_aluop(id_aluop), .id_funct(id_funct), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .id_hold(id_hold), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_aluop(id_aluop), .id_funct(id_funct), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_stall(ex_stall), .ex_valid(d2_valid),
    .ex_alusrc(d2_alusrc), .ex_memtoreg(d2_memtoreg), .ex_regwrite(d2_regwrite),
    .ex_memread(d2_memread), .ex_memwrite(d2_memwrite), .ex_branch(d2_branch),
    .ex_aluop(d2_aluop), .ex_funct(d2_funct), .ex_pc(d2_pc), .ex_rs1_data(d2_rs1_data),
    .ex_rs2_data(d2_rs2_data), .ex_imm(d2_imm), .ex_rs1(d2_rs1), .ex_rs2(d2_rs2),
    .ex_rd(d2_rd), .id_hold(d2_id_hold), .bubble_cnt(d2_bubble_cnt)
  );

  wire [8:0] ctrl1 = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                      ex_memwrite, ex_branch, ex_aluop};
  wire [8:0] ctrl2 = {d2_valid, d2_alusrc, d2_memtoreg, d2_regwrite, d2_memread,
                      d2_memwrite, d2_branch, d2_aluop};
  wire [274:0] data1 = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};
  wire [274:0] data2 = {d2_pc, d2_rs1_data, d2_rs2_data, d2_imm, d2_rs1, d2_rs2, d2_rd, d2_funct};

  int n_vec = 0;
  int n_bad = 0;
  model_t m;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // kind: 0 bubble/nop, 1 R-format, 2 ld, 3 sd, 4 beq
  function automatic in_t mk(input int kind, input int rd, input int rs1, input int rs2);
    in_t v;
    v = '0;
    v.valid = (kind != 0);
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.pc = 64'h40; v.rs1d = 64'd5; v.rs2d = 64'd7; v.imm = 64'hFFFF_FFFF_FFFF_FFF8;
    case (kind)
      1: begin v.regwrite = 1'b1; v.aluop = 2'b10; end
      2: begin v.alusrc = 1'b1; v.memtoreg = 1'b1; v.regwrite = 1'b1; v.memread = 1'b1; v.funct = 4'b0011; end
      3: begin v.alusrc = 1'b1; v.memwrite = 1'b1; v.funct = 4'b0011; end
      4: begin v.branch = 1'b1; v.aluop = 2'b01; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic in_t rst_in();
    in_t v;
    v = mk(1, 3, 1, 2);
    v.rst = 1'b1;
    {v.alusrc, v.memtoreg, v.regwrite, v.memread, v.memwrite, v.branch, v.aluop} = 8'hFF;
    return v;
  endfunction

  task automatic add(input in_t i, input bit ch, input bit h, input bit vld, input int rd,
                     input int c, input int c2);
    vec_t t;
    t.in = i; t.chk_hold = ch; t.exp_hold = h; t.exp_valid = vld;
    t.exp_rd = 5'(rd); t.exp_cnt = c; t.exp_cnt2 = c2;
    tbl.push_back(t);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; flush = v.flush; ex_stall = v.stall; id_valid = v.valid;
    id_alusrc = v.alusrc; id_memtoreg = v.memtoreg; id_regwrite = v.regwrite;
    id_memread = v.memread; id_memwrite = v.memwrite; id_branch = v.branch;
    id_aluop = v.aluop; id_funct = v.funct; id_pc = v.pc; id_rs1_data = v.rs1d;
    id_rs2_data = v.rs2d; id_imm = v.imm; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
  endtask

  // The ID instruction reads a register the load sitting in EX has yet to produce.
  function automatic bit hazard(input in_t v);
    bit reads_rs2;
    reads_rs2 = !v.alusrc || v.memwrite;
    if (!(m.valid && m.memread && v.valid) || m.rd == 5'd0) return 1'b0;
    return (m.rd == v.rs1) || (reads_rs2 && m.rd == v.rs2);
  endfunction

  task automatic model_update(input in_t v, input bit hz);
    if (v.rst) begin
      m.init = 1; m.valid = 0; m.memread = 0; m.rd = '0; m.ctrl = '0; m.data = '0;
      m.known = 1; m.cnt = 0; m.cnt2 = 0;
    end else if (v.flush) begin
      m.valid = 0; m.memread = 0; m.ctrl = '0; m.known = 0;
    end else if (v.stall) begin
      m.valid = m.valid;
    end else if (hz) begin
      m.valid = 0; m.memread = 0; m.ctrl = '0; m.known = 0;
      if (m.cnt < 65535) m.cnt = m.cnt + 1;
      if (m.cnt2 < 3) m.cnt2 = m.cnt2 + 1;
    end else begin
      m.valid = v.valid;
      m.memread = v.valid && v.memread;
      m.rd = v.rd;
      m.ctrl = v.valid ? {1'b1, v.alusrc, v.memtoreg, v.regwrite, v.memread, v.memwrite,
                          v.branch, v.aluop} : 9'd0;
      m.data = {v.pc, v.rs1d, v.rs2d, v.imm, v.rs1, v.rs2, v.rd, v.funct};
      m.known = 1;
    end
  endtask

  task automatic step(input in_t v, output logic hold_s);
    bit hz;
    @(negedge clk);
    drive(v);
    #1;
    hold_s = id_hold;
    hz = hazard(v);
    if (m.init) chk("hold_model", 320'({id_hold, d2_id_hold}),
                    320'({2{!v.flush && (v.stall || hz)}}));
    @(posedge clk);
    #1;
    model_update(v, hz);
    if (m.init) begin
      chk("ctrl", 320'(ctrl1), 320'(m.ctrl));
      chk("ctrl_w2", 320'(ctrl2), 320'(m.ctrl));
      chk("cnt_model", 320'(bubble_cnt), 320'(m.cnt));
      chk("cnt_w2_model", 320'(d2_bubble_cnt), 320'(m.cnt2));
      if (m.known) begin
        chk("data", 320'(data1), 320'(m.data));
        chk("data_w2", 320'(data2), 320'(m.data));
      end
    end
  endtask

  function automatic in_t rnd();
    in_t v;
    v = mk(int'($urandom_range(1, 4)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    v.pc = {$urandom, $urandom}; v.rs1d = {$urandom, $urandom};
    v.rs2d = {$urandom, $urandom}; v.imm = {$urandom, $urandom};
    v.funct = 4'($urandom);
    if ($urandom_range(0, 9) < 2) begin
      v.valid = 1'b0;
      {v.alusrc, v.memtoreg, v.regwrite, v.memread, v.memwrite, v.branch, v.aluop} = 8'($urandom);
    end
    v.flush = ($urandom_range(0, 19) == 0);
    v.stall = ($urandom_range(0, 7) == 0);
    v.rst   = ($urandom_range(0, 199) == 0);
    return v;
  endfunction

  initial begin
    in_t v;
    logic h;
    m = '{default: 0};

    add(rst_in(), 0, 0, 0, 0, 0, 0);
    add(rst_in(), 0, 0, 0, 0, 0, 0);
    add(mk(1, 3, 1, 2), 1, 0, 1, 3, 0, 0);   // add x3,x1,x2
    add(mk(2, 5, 1, 0), 1, 0, 1, 5, 0, 0);   // ld x5
    add(mk(1, 6, 5, 7), 1, 1, 0, 0, 1, 1);   // add x6,x5,x7 -> bubble
    add(mk(1, 6, 5, 7), 1, 0, 1, 6, 1, 1);
    add(mk(2, 5, 1, 0), 1, 0, 1, 5, 1, 1);   // ld x5
    add(mk(3, 0, 9, 5), 1, 1, 0, 0, 2, 2);   // sd x5,0(x9) -> bubble
    add(mk(3, 0, 9, 5), 1, 0, 1, 0, 2, 2);
    add(mk(2, 0, 1, 0), 1, 0, 1, 0, 2, 2);   // ld x0
    add(mk(1, 1, 0, 2), 1, 0, 1, 1, 2, 2);   // reads x0: no hazard
    add(mk(2, 5, 1, 0), 1, 0, 1, 5, 2, 2);   // ld x5
    add(mk(2, 8, 1, 5), 1, 0, 1, 8, 2, 2);   // ld x8 with rs2 field 5: no hazard
    add(mk(2, 5, 1, 0), 1, 0, 1, 5, 2, 2);   // ld x5
    v = mk(1, 6, 5, 7); v.valid = 1'b0;
    add(v, 1, 0, 0, 0, 2, 2);                // invalid ID: no hazard
    add(mk(1, 3, 1, 2), 1, 0, 1, 3, 2, 2);
    v = mk(2, 9, 1, 0); v.stall = 1'b1;
    for (int k = 0; k < 3; k++) add(v, 1, 1, 1, 3, 2, 2);
    add(mk(2, 9, 1, 0), 1, 0, 1, 9, 2, 2);   // ld x9
    v = mk(1, 10, 9, 2); v.flush = 1'b1; v.stall = 1'b1;
    add(v, 1, 0, 0, 0, 2, 2);                // flush beats load-use and stall
    add(mk(0, 0, 0, 0), 1, 0, 0, 0, 2, 2);
    add(rst_in(), 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(mk(2, 5, 1, 0), 1, 0, 1, 5, k, (k < 3) ? k : 3);
      add(mk(1, 6, 5, 7), 1, 1, 0, 0, k + 1, (k + 1 < 3) ? k + 1 : 3);
      add(mk(1, 6, 5, 7), 1, 0, 1, 6, k + 1, (k + 1 < 3) ? k + 1 : 3);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in, h);
      if (tbl[i].chk_hold) chk($sformatf("hold[%0d]", i), 320'(h), 320'(tbl[i].exp_hold));
      chk($sformatf("valid[%0d]", i), 320'(ex_valid), 320'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("rd[%0d]", i), 320'(ex_rd), 320'(tbl[i].exp_rd));
      chk($sformatf("cnt[%0d]", i), 320'(bubble_cnt), 320'(tbl[i].exp_cnt));
      chk($sformatf("cnt_w2[%0d]", i), 320'(d2_bubble_cnt), 320'(tbl[i].exp_cnt2));
    end

    step(rst_in(), h);
    for (int i = 0; i < 3000; i++) step(rnd(), h);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
